// File: rtl/subservient_boot_loader_pkg.sv
// rtl/subservient_boot_loader_pkg.sv - shared state encoding and helpers for the boot loader
package subservient_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int HDR_BYTES = 4;

  // Byte enables for a word holding the first <fill> lanes
  function automatic logic [3:0] fill_to_sel(input logic [2:0] fill);
    case (fill)
      3'd1:    fill_to_sel = 4'b0001;
      3'd2:    fill_to_sel = 4'b0011;
      3'd3:    fill_to_sel = 4'b0111;
      default: fill_to_sel = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/subservient_boot_loader_byte_packer.sv
// rtl/subservient_boot_loader_byte_packer.sv - packs bytes into little-endian word lanes
// Outputs reflect the word including a byte pushed this cycle, so the caller can launch on that edge.
module subservient_byte_packer
  import subservient_boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [3:0]  o_sel,
  output logic [2:0]  o_fill
);

  logic [31:0] word_q, word_d;
  logic [2:0]  fill_q, fill_d;

  always_comb begin
    o_word = word_q;
    if (i_push) begin
      o_word[{fill_q[1:0], 3'b000} +: 8] = i_byte;
    end
    o_fill = fill_q + {2'b00, i_push};
    o_sel  = fill_to_sel(o_fill);
    word_d = i_clear ? 32'd0 : o_word;
    fill_d = i_clear ? 3'd0 : o_fill;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_q <= 32'd0;
      fill_q <= 3'd0;
    end else begin
      word_q <= word_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/subservient_boot_loader.sv
// rtl/subservient_boot_loader.sv - length-prefixed stream loader writing SRAM over the debug port
// Holds the CPU in reset/debug until the whole image is written, then releases it.
module subservient_boot_loader
  import subservient_boot_loader_pkg::*;
#(
  parameter int memsize   = 512,
  parameter int max_bytes = 368
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_debug_mode,
  output logic        o_cpu_rst,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic        i_wb_dbg_ack,
  output logic        o_done,
  output logic        o_err
);

  localparam int AW = $clog2(memsize);

  state_e         state_q, state_d;
  logic [31:0]    rem_q, rem_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           ready_q, ready_d;
  logic           debug_q, debug_d;
  logic           cpu_rst_q, cpu_rst_d;
  logic           stb_q, stb_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     sel_q, sel_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           accept;
  logic           pk_clear;
  logic [31:0]    pk_word;
  logic [3:0]     pk_sel;
  logic [2:0]     pk_fill;

  assign accept = i_byte_valid & ready_q;

  subservient_byte_packer u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_clear (pk_clear),
    .i_byte  (i_byte),
    .o_word  (pk_word),
    .o_sel   (pk_sel),
    .o_fill  (pk_fill)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    stb_d    = stb_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    pk_clear = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (accept && pk_fill == 3'(HDR_BYTES)) begin
          pk_clear = 1'b1;
          rem_d    = pk_word;
          if (pk_word == 32'd0)                 state_d = ST_DONE;
          else if (pk_word > 32'(max_bytes))    state_d = ST_ERR;
          else                                  state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          rem_d = rem_q - 32'd1;
          if (pk_fill == 3'd4 || rem_q == 32'd1) begin
            state_d  = ST_WRITE;
            pk_clear = 1'b1;
            stb_d    = 1'b1;
            adr_d    = 32'(addr_q);
            dat_d    = pk_word;
            sel_d    = pk_sel;
          end
        end
      end
      ST_WRITE: begin
        if (i_wb_dbg_ack) begin
          stb_d   = 1'b0;
          addr_d  = addr_q + {{(AW-3){1'b0}}, 3'd4};
          state_d = (rem_q == 32'd0) ? ST_DONE : ST_DATA;
        end
      end
      default: ;
    endcase
    ready_d   = (state_d == ST_HDR) || (state_d == ST_DATA);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERR);
    debug_d   = (state_d != ST_DONE);
    cpu_rst_d = (state_d != ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_HDR;
      rem_q     <= 32'd0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      debug_q   <= 1'b1;
      cpu_rst_q <= 1'b1;
      stb_q     <= 1'b0;
      adr_q     <= 32'd0;
      dat_q     <= 32'd0;
      sel_q     <= 4'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      ready_q   <= ready_d;
      debug_q   <= debug_d;
      cpu_rst_q <= cpu_rst_d;
      stb_q     <= stb_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_byte_ready = ready_q;
  assign o_debug_mode = debug_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_wb_dbg_adr = adr_q;
  assign o_wb_dbg_dat = dat_q;
  assign o_wb_dbg_sel = sel_q;
  assign o_wb_dbg_we  = 1'b1;
  assign o_wb_dbg_stb = stb_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_subservient_boot_loader.sv
// tb/tb_subservient_boot_loader.sv - directed bench for subservient_boot_loader
module tb_subservient_boot_loader;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_byte = 8'd0;
  logic        i_byte_valid = 1'b0;
  logic        o_byte_ready, o_debug_mode, o_cpu_rst;
  logic [31:0] o_wb_dbg_adr, o_wb_dbg_dat;
  logic [3:0]  o_wb_dbg_sel;
  logic        o_wb_dbg_we, o_wb_dbg_stb;
  logic        i_wb_dbg_ack = 1'b0;
  logic        o_done, o_err;

  int n_checks = 0;
  int n_errors = 0;

  int          ack_delay = 0;
  int          hold = 0;
  logic [31:0] first_adr, first_dat;
  logic [3:0]  first_sel;
  bit          unstable = 0;
  bit          ready_in_write = 0;
  logic [31:0] wl_adr[$];
  logic [31:0] wl_dat[$];
  logic [3:0]  wl_sel[$];
  int          wl_hold[$];

  always #5 clk = ~clk;

  subservient_boot_loader dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_debug_mode (o_debug_mode),
    .o_cpu_rst    (o_cpu_rst),
    .o_wb_dbg_adr (o_wb_dbg_adr),
    .o_wb_dbg_dat (o_wb_dbg_dat),
    .o_wb_dbg_sel (o_wb_dbg_sel),
    .o_wb_dbg_we  (o_wb_dbg_we),
    .o_wb_dbg_stb (o_wb_dbg_stb),
    .i_wb_dbg_ack (i_wb_dbg_ack),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wishbone slave: acks after ack_delay extra cycles and logs every completed write
  always @(negedge clk) begin
    if (i_wb_dbg_ack) begin
      i_wb_dbg_ack = 1'b0;
    end else if (o_wb_dbg_stb) begin
      if (hold == 0) begin
        first_adr = o_wb_dbg_adr;
        first_dat = o_wb_dbg_dat;
        first_sel = o_wb_dbg_sel;
      end else if (o_wb_dbg_adr !== first_adr || o_wb_dbg_dat !== first_dat ||
                   o_wb_dbg_sel !== first_sel) begin
        unstable = 1;
      end
      if (o_byte_ready) ready_in_write = 1;
      hold++;
      if (hold > ack_delay) begin
        i_wb_dbg_ack = 1'b1;
        wl_adr.push_back(o_wb_dbg_adr);
        wl_dat.push_back(o_wb_dbg_dat);
        wl_sel.push_back(o_wb_dbg_sel);
        wl_hold.push_back(hold);
        hold = 0;
      end
    end else begin
      hold = 0;
    end
  end

  task automatic clear_log();
    wl_adr.delete();
    wl_dat.delete();
    wl_sel.delete();
    wl_hold.delete();
    unstable = 0;
    ready_in_write = 0;
  endtask

  task automatic do_reset();
    i_byte_valid = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_byte = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!o_done && !o_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("end_timeout", 32'd1, 32'd0);
    i_byte_valid = 1'b0;
  endtask

  task automatic check_write(input int idx, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
    if (wl_adr.size() > idx) begin
      check($sformatf("w%0d_adr", idx), wl_adr[idx], adr);
      check($sformatf("w%0d_dat", idx), wl_dat[idx], dat);
      check($sformatf("w%0d_sel", idx), 32'(wl_sel[idx]), 32'(sel));
    end else begin
      check($sformatf("w%0d_missing", idx), 32'(wl_adr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(o_byte_ready), 32'd0);
    check("rst_debug", 32'(o_debug_mode), 32'd1);
    check("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("rst_stb", 32'(o_wb_dbg_stb), 32'd0);
    check("rst_adr", o_wb_dbg_adr, 32'd0);
    check("rst_dat", o_wb_dbg_dat, 32'd0);
    check("rst_sel", 32'(o_wb_dbg_sel), 32'd0);
    check("rst_we", 32'(o_wb_dbg_we), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(o_byte_ready), 32'd1);

    // N = 8, zero-wait ack
    clear_log();
    send_word(32'd8);
    send_word(32'h14131211);
    send_word(32'h18171615);
    wait_end();
    check("n8_count", 32'(wl_adr.size()), 32'd2);
    check_write(0, 32'd0, 32'h14131211, 4'hF);
    check_write(1, 32'd4, 32'h18171615, 4'hF);
    check("n8_done", 32'(o_done), 32'd1);
    check("n8_cpu_rst", 32'(o_cpu_rst), 32'd0);
    check("n8_debug", 32'(o_debug_mode), 32'd0);
    check("n8_ready", 32'(o_byte_ready), 32'd0);
    check("n8_hold", 32'(wl_hold[0]), 32'd1);

    // N = 5, partial final word
    do_reset();
    send_word(32'd5);
    send_word(32'hDDCCBBAA);
    send_byte(8'hEE);
    wait_end();
    check("n5_count", 32'(wl_adr.size()), 32'd2);
    check_write(0, 32'd0, 32'hDDCCBBAA, 4'hF);
    check_write(1, 32'd4, 32'h000000EE, 4'h1);
    check("n5_done", 32'(o_done), 32'd1);

    // N = 8, three-cycle stb hold, valid held high throughout
    do_reset();
    ack_delay = 2;
    send_word(32'd8);
    send_word(32'h24232221);
    send_word(32'h28272625);
    wait_end();
    ack_delay = 0;
    check("slow_count", 32'(wl_adr.size()), 32'd2);
    check_write(0, 32'd0, 32'h24232221, 4'hF);
    check_write(1, 32'd4, 32'h28272625, 4'hF);
    if (wl_hold.size() == 2) begin
      check("slow_hold0", 32'(wl_hold[0]), 32'd3);
      check("slow_hold1", 32'(wl_hold[1]), 32'd3);
    end
    check("slow_stable", 32'(unstable), 32'd0);
    check("slow_ready_low", 32'(ready_in_write), 32'd0);
    check("slow_done", 32'(o_done), 32'd1);

    // Header 369 rejected, input then ignored
    do_reset();
    send_word(32'd369);
    check("err_flag", 32'(o_err), 32'd1);
    check("err_ready", 32'(o_byte_ready), 32'd0);
    check("err_cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("err_debug", 32'(o_debug_mode), 32'd1);
    i_byte = 8'h55;
    i_byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    i_byte_valid = 1'b0;
    check("err_no_write", 32'(wl_adr.size()), 32'd0);
    check("err_sticky", 32'(o_err), 32'd1);
    check("err_not_done", 32'(o_done), 32'd0);

    // Header 368 is the largest accepted length
    do_reset();
    send_word(32'd368);
    i_byte_valid = 1'b0;
    check("max_no_err", 32'(o_err), 32'd0);
    check("max_ready", 32'(o_byte_ready), 32'd1);

    // Header 0 completes at once
    do_reset();
    send_word(32'd0);
    i_byte_valid = 1'b0;
    check("zero_done", 32'(o_done), 32'd1);
    check("zero_cpu_rst", 32'(o_cpu_rst), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_write", 32'(wl_adr.size()), 32'd0);

    // Reset during write of word 2, then reload
    do_reset();
    ack_delay = 10;
    send_word(32'd8);
    send_word(32'h34333231);
    send_word(32'h38373635);
    i_byte_valid = 1'b0;
    n = 0;
    while (!(wl_adr.size() == 1 && o_wb_dbg_stb) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_word2_adr", o_wb_dbg_adr, 32'd4);
    i_rst = 1'b1;
    @(negedge clk);
    check("mid_stb", 32'(o_wb_dbg_stb), 32'd0);
    check("mid_debug", 32'(o_debug_mode), 32'd1);
    check("mid_cpu_rst", 32'(o_cpu_rst), 32'd1);
    i_rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    clear_log();
    send_word(32'd4);
    send_word(32'h5D5C5B5A);
    wait_end();
    check("reload_count", 32'(wl_adr.size()), 32'd1);
    check_write(0, 32'd0, 32'h5D5C5B5A, 4'hF);
    check("reload_done", 32'(o_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
